// File: rtl/gray_ptr_sync.sv
`timescale 1ns/1ps
// gray_ptr_sync
// Brings a Gray-coded async-FIFO pointer from a foreign clock domain into clk
// through a plain flop chain. It also produces the registered binary value, a
// one-cycle advance pulse with the advance amount, and a sticky violation flag
// with a saturating error count. A short warm-up after reset hides the
// reset-to-live-pointer jump while the chain fills.
module gray_ptr_sync #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_WIDTH:0] gray_in,
  input  logic                err_clr,
  output logic [ADDR_WIDTH:0] gray_out,
  output logic [ADDR_WIDTH:0] bin_out,
  output logic                ptr_adv,
  output logic [ADDR_WIDTH:0] adv_cnt,
  output logic                gray_err,
  output logic [7:0]          err_cnt
);

  // Warm-up spans the chain fill plus the binary register.
  localparam logic [2:0] WU_MAX = 3'(SYNC_STAGES + 1);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] gray_prev;
  logic [2:0]          wu_cnt;

  logic [ADDR_WIDTH:0] gray_diff;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] adv_next;
  logic                is_change;
  logic                is_viol;
  logic                warm_done;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchronizer chain: nothing but flops between stages so each stage has a
  // full cycle to resolve metastability.
  // NOTE: every stage is reset explicitly; this is a small flop chain, not a
  // RAM, so clearing it costs nothing and keeps the post-reset value defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of
      // its predecessor, which is what makes this a shift chain.
      sync_q[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign gray_out = sync_q[SYNC_STAGES-1];

  // Change and violation detection against the previous synchronized sample.
  // diff & (diff - 1) drops the lowest set bit; anything left means two or
  // more bits flipped, which a legal Gray step never does.
  assign gray_diff = gray_out ^ gray_prev;
  assign is_change = |gray_diff;
  assign is_viol   = (gray_diff & (gray_diff - PTR_ONE)) != '0;
  assign bin_next  = gray2bin(gray_out);
  // bin_out always holds the binary of gray_prev, so this is the step size,
  // wrapping naturally modulo 2^PW.
  assign adv_next  = bin_next - bin_out;
  assign warm_done = (wu_cnt == WU_MAX);

  // Warm-up counter: counts edges after reset and parks at WU_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_cnt <= '0;
    end else if (!warm_done) begin
      wu_cnt <= wu_cnt + 3'd1;
    end
  end

  // Previous-sample and binary registers track gray_out every cycle,
  // warm-up or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_prev <= '0;
      bin_out   <= '0;
    end else begin
      gray_prev <= gray_out;
      bin_out   <= bin_next;
    end
  end

  // Advance pulse and amount, registered alongside the bin_out update and
  // suppressed during warm-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_adv <= 1'b0;
      adv_cnt <= '0;
    end else if (warm_done && is_change) begin
      ptr_adv <= 1'b1;
      adv_cnt <= adv_next;
    end else begin
      ptr_adv <= 1'b0;
      adv_cnt <= '0;
    end
  end

  // Sticky violation flag and saturating count; a violation in the same
  // cycle as err_clr wins and restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_err <= 1'b0;
      err_cnt  <= '0;
    end else if (warm_done && is_viol) begin
      gray_err <= 1'b1;
      if (err_clr) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (err_clr) begin
      gray_err <= 1'b0;
      err_cnt  <= '0;
    end
  end

`ifndef SYNTHESIS
  // Parameter sanity, evaluated in simulation only.
  always_ff @(posedge clk) begin
    assert (SYNC_STAGES >= 2 && SYNC_STAGES <= 4)
      else $error("gray_ptr_sync: SYNC_STAGES must be 2..4");
    assert (FIFO_DEPTH > 0 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)
      else $error("gray_ptr_sync: FIFO_DEPTH must be a power of two");
  end
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
`timescale 1ns/1ps
// Bench for gray_ptr_sync (FIFO_DEPTH=8, SYNC_STAGES=2, 4-bit pointers).
// Directed scenarios plus a randomized run compared against a history-based
// reference model.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'd0;
  logic       err_clr = 1'b0;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       ptr_adv;
  logic [3:0] adv_cnt;
  logic       gray_err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: every value presented at each edge since reset release.
  logic [3:0] hist[$];
  int         n_edges = 0;
  logic [3:0] exp_gout, exp_bout, exp_advc;
  logic       exp_adv, exp_err;
  logic [7:0] exp_cnt;

  gray_ptr_sync #(
    .FIFO_DEPTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .gray_out(gray_out),
    .bin_out (bin_out),
    .ptr_adv (ptr_adv),
    .adv_cnt (adv_cnt),
    .gray_err(gray_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Value presented at edge k (1-based); stages hold 0 before the first edge.
  function automatic logic [3:0] val(input int k);
    if (k < 1) return 4'd0;
    return hist[k-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges  = 0;
    exp_gout = '0;
    exp_bout = '0;
    exp_adv  = 1'b0;
    exp_advc = '0;
    exp_err  = 1'b0;
    exp_cnt  = '0;
  endtask

  // Two-stage chain: gray_out after edge n is the input of edge n-1, bin_out
  // that of edge n-2. Reporting starts at the 4th edge after release.
  task automatic model_edge(input logic clr);
    logic [3:0] a, p;
    a = val(n_edges - 2);
    p = val(n_edges - 3);
    exp_gout = val(n_edges - 1);
    exp_bout = g2b(a);
    if (n_edges >= 4 && a != p) begin
      exp_adv  = 1'b1;
      exp_advc = g2b(a) - g2b(p);
    end else begin
      exp_adv  = 1'b0;
      exp_advc = 4'd0;
    end
    if (n_edges >= 4 && $countones(a ^ p) >= 2) begin
      exp_err = 1'b1;
      if (clr) exp_cnt = 8'd1;
      else if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
    end else if (clr) begin
      exp_err = 1'b0;
      exp_cnt = 8'd0;
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, return at the next
  // falling edge with the model updated.
  task automatic drive_cycle(input logic [3:0] g, input logic clr);
    gray_in = g;
    err_clr = clr;
    @(posedge clk);
    hist.push_back(g);
    n_edges++;
    model_edge(clr);
    @(negedge clk);
  endtask

  // Assert reset between edges; returns with rst still high.
  task automatic apply_reset(input logic [3:0] g);
    gray_in = g;
    err_clr = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    model_reset();
    total += 6;
    if (gray_out !== 4'd0) begin bad++; $display("FAIL reset_gray_out got=%h exp=0", gray_out); end
    if (bin_out  !== 4'd0) begin bad++; $display("FAIL reset_bin_out got=%h exp=0", bin_out); end
    if (ptr_adv  !== 1'b0) begin bad++; $display("FAIL reset_ptr_adv got=%b exp=0", ptr_adv); end
    if (adv_cnt  !== 4'd0) begin bad++; $display("FAIL reset_adv_cnt got=%h exp=0", adv_cnt); end
    if (gray_err !== 1'b0) begin bad++; $display("FAIL reset_gray_err got=%b exp=0", gray_err); end
    if (err_cnt  !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'd0, 1'b0);
      total += 2;
      if (ptr_adv !== 1'b0) begin bad++; $display("FAIL reset_rel_adv edge=%0d got=%b exp=0", i + 1, ptr_adv); end
      if (gray_err !== 1'b0) begin bad++; $display("FAIL reset_rel_err edge=%0d got=%b exp=0", i + 1, gray_err); end
    end
  endtask

  task automatic test_single_step();
    drive_cycle(4'd0, 1'b0);
    drive_cycle(4'b0001, 1'b0);  // edge E
    total++;
    if (ptr_adv !== 1'b0) begin bad++; $display("FAIL step_e_adv got=%b exp=0", ptr_adv); end
    drive_cycle(4'b0001, 1'b0);  // E+1
    total += 2;
    if (gray_out !== 4'b0001) begin bad++; $display("FAIL step_gray_out got=%b exp=0001", gray_out); end
    if (bin_out !== 4'd0) begin bad++; $display("FAIL step_bin_early got=%0d exp=0", bin_out); end
    drive_cycle(4'b0001, 1'b0);  // E+2
    total += 3;
    if (bin_out !== 4'd1) begin bad++; $display("FAIL step_bin got=%0d exp=1", bin_out); end
    if (ptr_adv !== 1'b1) begin bad++; $display("FAIL step_adv got=%b exp=1", ptr_adv); end
    if (adv_cnt !== 4'd1) begin bad++; $display("FAIL step_adv_cnt got=%0d exp=1", adv_cnt); end
    drive_cycle(4'b0001, 1'b0);  // E+3
    total += 2;
    if (ptr_adv !== 1'b0) begin bad++; $display("FAIL step_adv_end got=%b exp=0", ptr_adv); end
    if (adv_cnt !== 4'd0) begin bad++; $display("FAIL step_cnt_end got=%0d exp=0", adv_cnt); end
  endtask

  // Walk 2..15 one step per cycle (back-to-back pulses), then wrap to 0.
  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 14; i++) begin
      drive_cycle(b2g(4'(i + 2)), 1'b0);
      if (i >= 2) begin
        total += 2;
        if (ptr_adv !== 1'b1) begin bad++; $display("FAIL b2b_adv step=%0d got=%b exp=1", i, ptr_adv); end
        if (adv_cnt !== 4'd1) begin bad++; $display("FAIL b2b_cnt step=%0d got=%0d exp=1", i, adv_cnt); end
      end
    end
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    total += 4;
    if (bin_out !== 4'd0) begin bad++; $display("FAIL wrap_bin got=%0d exp=0", bin_out); end
    if (ptr_adv !== 1'b1) begin bad++; $display("FAIL wrap_adv got=%b exp=1", ptr_adv); end
    if (adv_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", adv_cnt); end
    if (gray_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", gray_err); end
  endtask

  task automatic test_violation();
    repeat (4) drive_cycle(4'b0001, 1'b0);
    drive_cycle(4'b0110, 1'b0);
    drive_cycle(4'b0110, 1'b0);
    drive_cycle(4'b0110, 1'b0);
    total += 5;
    if (bin_out !== 4'd4) begin bad++; $display("FAIL viol_bin got=%0d exp=4", bin_out); end
    if (ptr_adv !== 1'b1) begin bad++; $display("FAIL viol_adv got=%b exp=1", ptr_adv); end
    if (adv_cnt !== 4'd3) begin bad++; $display("FAIL viol_cnt got=%0d exp=3", adv_cnt); end
    if (gray_err !== 1'b1) begin bad++; $display("FAIL viol_err got=%b exp=1", gray_err); end
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL viol_err_cnt got=%0d exp=1", err_cnt); end
    drive_cycle(4'b0110, 1'b0);
    drive_cycle(4'b0110, 1'b1);
    total += 3;
    if (gray_err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", gray_err); end
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
    if (bin_out !== 4'd4) begin bad++; $display("FAIL clr_bin got=%0d exp=4", bin_out); end
    // Violation lands on the same edge as err_clr, starting from count 0.
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b1);
    total += 2;
    if (gray_err !== 1'b1) begin bad++; $display("FAIL coin0_err got=%b exp=1", gray_err); end
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL coin0_cnt got=%0d exp=1", err_cnt); end
    // And again with the count already at 1: still restarts at 1.
    drive_cycle(4'b0110, 1'b0);
    drive_cycle(4'b0110, 1'b0);
    drive_cycle(4'b0110, 1'b1);
    total += 3;
    if (gray_err !== 1'b1) begin bad++; $display("FAIL coin1_err got=%b exp=1", gray_err); end
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL coin1_cnt got=%0d exp=1", err_cnt); end
    if (ptr_adv !== 1'b1) begin bad++; $display("FAIL coin1_adv got=%b exp=1", ptr_adv); end
    drive_cycle(4'b0110, 1'b0);
  endtask

  task automatic test_warmup();
    apply_reset(4'b0101);
    release_reset();
    for (int e = 1; e <= 6; e++) begin
      drive_cycle(4'b0101, 1'b0);
      total += 2;
      if (ptr_adv !== 1'b0) begin bad++; $display("FAIL warm_adv edge=%0d got=%b exp=0", e, ptr_adv); end
      if (gray_err !== 1'b0) begin bad++; $display("FAIL warm_err edge=%0d got=%b exp=0", e, gray_err); end
      if (e == 2) begin
        total += 2;
        if (gray_out !== 4'b0101) begin bad++; $display("FAIL warm_gray edge=2 got=%b exp=0101", gray_out); end
        if (bin_out !== 4'd0) begin bad++; $display("FAIL warm_bin_early edge=2 got=%0d exp=0", bin_out); end
      end
      if (e == 3) begin
        total++;
        if (bin_out !== 4'd6) begin bad++; $display("FAIL warm_bin edge=3 got=%0d exp=6", bin_out); end
      end
    end
  endtask

  task automatic test_mid_reset();
    repeat (3) drive_cycle(4'b0000, 1'b0);
    repeat (3) drive_cycle(4'b0101, 1'b0);
    total += 2;
    if (bin_out !== 4'd6) begin bad++; $display("FAIL mid_pre_bin got=%0d exp=6", bin_out); end
    if (err_cnt !== 8'd2) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=2", err_cnt); end
    apply_reset(4'b0101);
    total += 6;
    if (gray_out !== 4'd0) begin bad++; $display("FAIL mid_gray_out got=%h exp=0", gray_out); end
    if (bin_out  !== 4'd0) begin bad++; $display("FAIL mid_bin_out got=%h exp=0", bin_out); end
    if (ptr_adv  !== 1'b0) begin bad++; $display("FAIL mid_ptr_adv got=%b exp=0", ptr_adv); end
    if (adv_cnt  !== 4'd0) begin bad++; $display("FAIL mid_adv_cnt got=%h exp=0", adv_cnt); end
    if (gray_err !== 1'b0) begin bad++; $display("FAIL mid_gray_err got=%b exp=0", gray_err); end
    if (err_cnt  !== 8'd0) begin bad++; $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); end
    release_reset();
  endtask

  task automatic test_saturation();
    repeat (4) drive_cycle(4'b0000, 1'b0);
    for (int i = 0; i < 305; i++) begin
      drive_cycle((i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
    end
    repeat (3) drive_cycle(4'b0000, 1'b0);
    total += 2;
    if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", err_cnt); end
    if (gray_err !== 1'b1) begin bad++; $display("FAIL sat_err got=%b exp=1", gray_err); end
  endtask

  task automatic test_random();
    logic [3:0] b;
    int         r;
    logic       clr;
    apply_reset(4'd0);
    release_reset();
    b = 4'd0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        apply_reset(b2g(b));
        release_reset();
      end
      r = $urandom_range(0, 99);
      if (r >= 45 && r < 85) b = b + 4'd1;
      else if (r >= 85) b = 4'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      drive_cycle(b2g(b), clr);
      total += 6;
      if (gray_out !== exp_gout) begin bad++; $display("FAIL rnd_gray_out cyc=%0d got=%h exp=%h", i, gray_out, exp_gout); end
      if (bin_out !== exp_bout) begin bad++; $display("FAIL rnd_bin_out cyc=%0d got=%h exp=%h", i, bin_out, exp_bout); end
      if (ptr_adv !== exp_adv) begin bad++; $display("FAIL rnd_ptr_adv cyc=%0d got=%b exp=%b", i, ptr_adv, exp_adv); end
      if (adv_cnt !== exp_advc) begin bad++; $display("FAIL rnd_adv_cnt cyc=%0d got=%h exp=%h", i, adv_cnt, exp_advc); end
      if (gray_err !== exp_err) begin bad++; $display("FAIL rnd_gray_err cyc=%0d got=%b exp=%b", i, gray_err, exp_err); end
      if (err_cnt !== exp_cnt) begin bad++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d exp=%0d", i, err_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back_wrap();
    test_violation();
    test_warmup();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised multi-stage synchronizer for async-FIFO Gray-coded pointers, instantiated once per direction (write pointer into the read domain, read pointer into the write domain). It takes a Gray pointer from the foreign clock domain through SYNC_STAGES flops. It then provides:
- the synchronized Gray value;
- its registered binary equivalent;
- a per-cycle advance pulse and advance amount;
- a sticky Gray-violation monitor with a saturating error count.

A post-reset warm-up window masks advance and error reporting while the chain fills.

## Interface
- FIFO_DEPTH, 8: FIFO entries, power of two.
- ADDR_WIDTH, $clog2(FIFO_DEPTH): address bits. Pointers are ADDR_WIDTH+1 bits (PW).
- SYNC_STAGES, 2: synchronizer depth. Legal range 2..4.
- clk  in  1  destination-domain clock.
- rst  in  1  asynchronous, active-high reset. Clears all state.
- gray_in  in  PW  Gray pointer from the foreign domain, asynchronous to clk.
- err_clr  in  1  synchronous clear of gray_err and err_cnt.
- gray_out  out  PW  last synchronizer stage.
- bin_out  out  PW  registered Gray-to-binary of gray_out.
- ptr_adv  out  1  one-cycle pulse when bin_out changes value.
- adv_cnt  out  PW  (new bin_out − previous bin_out) mod 2^PW. Valid while ptr_adv=1, otherwise 0.
- gray_err  out  1  sticky: consecutive gray_out samples differed in more than one bit.
- err_cnt  out  8  saturating count of violations (stops at 255).

## Operation
- Sync chain: stage[0] <= gray_in; stage[k] <= stage[k-1]. gray_out = stage[SYNC_STAGES-1]. No logic between stages.
- Conversion: bin_out is registered from gray_out. Bit PW-1 = g[PW-1]; bit i = b[i+1] ^ g[i].
- Previous-sample register gray_prev <= gray_out every cycle.
- Change detection uses d = gray_out ^ gray_prev.
  - popcount(d) ≥ 1: change.
  - popcount(d) ≥ 2: violation.
- Advance:
  - On a change: ptr_adv=1 and adv_cnt = bin(gray_out) − bin_out, truncated to PW bits. Both are registered together with the bin_out update.
  - Otherwise: ptr_adv=0 and adv_cnt=0.
- Error:
  - A violation sets gray_err and increments err_cnt (saturating at 255).
  - err_clr=1 clears both.
  - Violation and err_clr in the same cycle: the set wins. gray_err=1 and err_cnt=1.
- Warm-up counter (0..SYNC_STAGES+1) is cleared by reset and increments each cycle until it saturates at SYNC_STAGES+1.
  - While not saturated: bin_out and gray_out still track, but ptr_adv=0, adv_cnt=0, and no violation is recorded.
  - Effect: the reset-time jump from 0 to a live pointer is never reported.
- Wrap-around: binary arithmetic is modulo 2^PW. For PW=4, 15→0 gives adv_cnt=1.
- Assertions are simulation-only:
  - SYNC_STAGES is in 2..4;
  - FIFO_DEPTH is a power of two.

## Timing
- Reset values: every stage, gray_prev, gray_out, bin_out, ptr_adv, adv_cnt, gray_err, err_cnt and the warm-up counter are 0. Clearing is immediate on rst assertion, independent of clk.
- Reset mid-operation: outputs go to 0 asynchronously, and the warm-up restarts on release.
- gray_in stable before edge E (counting E as edge 1):
  - gray_out updates at edge SYNC_STAGES;
  - bin_out, ptr_adv, adv_cnt and gray_err update at edge SYNC_STAGES+1.
- Warm-up covers the first SYNC_STAGES+1 edges after rst deasserts. Reporting starts on the following edge.
- ptr_adv is exactly one cycle wide per change. Back-to-back changes give back-to-back pulses.
- err_clr takes effect at the next edge. It never affects bin_out or ptr_adv.

## Test plan
All scenarios use FIFO_DEPTH=8 (PW=4) and SYNC_STAGES=2.
- Reset: hold rst=1 with gray_in=0000 -> all outputs 0. After release, no ptr_adv and gray_err=0 for 3 edges.
- Single step after warm-up: gray_in 0000→0001 before edge E.
  - gray_out=0001 at E+1.
  - At E+2: bin_out=1, ptr_adv=1, adv_cnt=1.
  - At E+3: ptr_adv=0, adv_cnt=0.
- Wrap: gray_in 1000 (15)→0000 -> bin_out=0, ptr_adv=1, adv_cnt=1, gray_err=0.
- Violation: gray_in jumps 0001→0110 (bin 1→4) -> ptr_adv=1, adv_cnt=3, gray_err=1, err_cnt=1.
  - Then err_clr one cycle with no violation -> gray_err=0, err_cnt=0.
  - Then a violation coincident with err_clr -> gray_err=1, err_cnt=1.
- Warm-up masking: release rst with gray_in=0101 held (bin 6) -> bin_out=6 at edge 3, ptr_adv never asserts, gray_err=0.
- Reset mid-operation: with bin_out=6 and err_cnt=2, assert rst between edges -> all outputs 0 before the next edge.
  - Saturation: 300 forced violations -> err_cnt=255.
